modexp: RTL



---
 rtl/modexp.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/modexp.sv
// ---------------------------------------------------------------------------
// modexp
//
// Modular exponentiation sequencer: base^exponent mod modulus, computed by
// left-to-right square-and-multiply. The block never reduces anything by
// itself. Each product is formed here, handed to an external reduction unit,
// and the reduced result is read back.
//
// Parameters
//   WIDTH      reduction-port width; must be even. Operands are WIDTH/2 bits,
//              so every HALF x HALF product fits in WIDTH bits.
//   EXP_WIDTH  exponent width.
//
// Ports
//   clk_in, rst_in   clock, synchronous active-high reset
//   start_in         job request, sampled only while idle
//   base_in          base, captured on an accepted start
//   exponent_in      exponent, captured on an accepted start
//   modulus_in       modulus, captured on an accepted start
//   value_out        result, valid with valid_out, held until the next start
//   busy_out         high from the cycle after an accepted start up to the
//                    completion cycle
//   valid_out        one-cycle completion pulse
//   error_out        high together with valid_out when the modulus was zero
//   red_ready_out    one-cycle request strobe to the reduction unit
//   red_value_out    value to reduce, stable from the strobe until the result
//   red_modulus_out  captured modulus, zero-extended to WIDTH
//   red_busy_in      reduction unit busy; a new request is held off while high
//   red_valid_in     reduction result pulse
//   red_value_in     reduced value; only the low WIDTH/2 bits are used
// ---------------------------------------------------------------------------
module modexp #(
    parameter int WIDTH     = 16,
    parameter int EXP_WIDTH = 8
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   start_in,
    input  logic [WIDTH/2-1:0]     base_in,
    input  logic [EXP_WIDTH-1:0]   exponent_in,
    input  logic [WIDTH/2-1:0]     modulus_in,
    output logic [WIDTH/2-1:0]     value_out,
    output logic                   busy_out,
    output logic                   valid_out,
    output logic                   error_out,
    output logic                   red_ready_out,
    output logic [WIDTH-1:0]       red_value_out,
    output logic [WIDTH-1:0]       red_modulus_out,
    input  logic                   red_busy_in,
    input  logic                   red_valid_in,
    input  logic [WIDTH-1:0]       red_value_in
);

    localparam int HALF  = WIDTH / 2;
    localparam int BIT_W = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREP,
        ST_WAIT,
        ST_NEXT,
        ST_DONE
    } state_t;

    // Which product the current request carries. BASE is the initial
    // reduction of the raw base so later multiplies use a reduced operand.
    typedef enum logic [1:0] {
        OP_BASE,
        OP_SQR,
        OP_MUL
    } op_t;

    state_t                 state_q,    state_d;
    op_t                    op_q,       op_d;
    logic [BIT_W-1:0]       bit_q,      bit_d;
    logic [HALF-1:0]        base_q,     base_d;
    logic [EXP_WIDTH-1:0]   exp_q,      exp_d;
    logic [HALF-1:0]        mod_q,      mod_d;
    logic [HALF-1:0]        acc_q,      acc_d;
    logic [HALF-1:0]        rbase_q,    rbase_d;
    logic [WIDTH-1:0]       redValue_q, redValue_d;
    logic                   redReady_q, redReady_d;
    logic [HALF-1:0]        value_q,    value_d;
    logic                   busy_q,     busy_d;
    logic                   valid_q,    valid_d;
    logic                   error_q,    error_d;

    logic [WIDTH-1:0]       mulA;
    logic [WIDTH-1:0]       mulB;
    logic [WIDTH-1:0]       product;
    logic                   unusedRedUpper;

    // The reduction unit may return junk in its upper half; it is dropped.
    assign unusedRedUpper = ^red_value_in[WIDTH-1:HALF];

    // Single HALF x HALF multiplier shared by squaring and multiplying:
    // the left operand is always acc, the right one is acc or rbase.
    always_comb begin
        mulA    = {{HALF{1'b0}}, acc_q};
        mulB    = (op_q == OP_MUL) ? {{HALF{1'b0}}, rbase_q} : mulA;
        product = mulA * mulB;
    end

    // State and datapath registers.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= ST_IDLE;
            op_q       <= OP_BASE;
            bit_q      <= '0;
            base_q     <= '0;
            exp_q      <= '0;
            mod_q      <= '0;
            acc_q      <= '0;
            rbase_q    <= '0;
            redValue_q <= '0;
            redReady_q <= 1'b0;
            value_q    <= '0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            bit_q      <= bit_d;
            base_q     <= base_d;
            exp_q      <= exp_d;
            mod_q      <= mod_d;
            acc_q      <= acc_d;
            rbase_q    <= rbase_d;
            redValue_q <= redValue_d;
            redReady_q <= redReady_d;
            value_q    <= value_d;
            busy_q     <= busy_d;
            valid_q    <= valid_d;
            error_q    <= error_d;
        end
    end

    // Sequencer. Strobes (ready, valid, error) default low so they last one
    // cycle; everything else holds unless a state updates it.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        bit_d      = bit_q;
        base_d     = base_q;
        exp_d      = exp_q;
        mod_d      = mod_q;
        acc_d      = acc_q;
        rbase_d    = rbase_q;
        redValue_d = redValue_q;
        redReady_d = 1'b0;
        value_d    = value_q;
        busy_d     = busy_q;
        valid_d    = 1'b0;
        error_d    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start_in) begin
                    base_d  = base_in;
                    exp_d   = exponent_in;
                    mod_d   = modulus_in;
                    busy_d  = 1'b1;
                    value_d = '0;
                    if (modulus_in == '0) begin
                        // Nothing sensible to reduce against: report at once.
                        acc_d   = '0;
                        state_d = ST_DONE;
                    end else begin
                        acc_d   = {{(HALF-1){1'b0}}, 1'b1};
                        rbase_d = '0;
                        bit_d   = BIT_W'(EXP_WIDTH - 1);
                        op_d    = OP_BASE;
                        state_d = ST_PREP;
                    end
                end
            end

            ST_PREP: begin
                if (!red_busy_in) begin
                    redValue_d = (op_q == OP_BASE) ? {{HALF{1'b0}}, base_q}
                                                   : product;
                    redReady_d = 1'b1;
                    state_d    = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (red_valid_in) begin
                    if (op_q == OP_BASE) begin
                        rbase_d = red_value_in[HALF-1:0];
                    end else begin
                        acc_d = red_value_in[HALF-1:0];
                    end
                    state_d = ST_NEXT;
                end
            end

            ST_NEXT: begin
                // After a squaring with the current bit set, a multiply is
                // still owed for this bit; otherwise move to the next bit.
                if (op_q == OP_BASE) begin
                    op_d    = OP_SQR;
                    state_d = ST_PREP;
                end else if ((op_q == OP_SQR) && exp_q[bit_q]) begin
                    op_d    = OP_MUL;
                    state_d = ST_PREP;
                end else if (bit_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    bit_d   = bit_q - 1'b1;
                    op_d    = OP_SQR;
                    state_d = ST_PREP;
                end
            end

            ST_DONE: begin
                value_d = acc_q;
                valid_d = 1'b1;
                busy_d  = 1'b0;
                error_d = (mod_q == '0);
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign value_out       = value_q;
    assign busy_out        = busy_q;
    assign valid_out       = valid_q;
    assign error_out       = error_q;
    assign red_ready_out   = redReady_q;
    assign red_value_out   = redValue_q;
    assign red_modulus_out = {{HALF{1'b0}}, mod_q};

endmodule
